// File: rtl/core_pkg.sv
// Shared core definitions: hazard sequencer state encodings, the canonical NOP
// and the default register-file address width.
package core_pkg;

    localparam int unsigned DEF_REG_AW = 5;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // addi x0, x0, 0 -- what IF/ID carries while flushed
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational RAW comparator between an ID reader and an EX writer.
// x0 and disabled reads never match.
module hazard_detect
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic              rs1_re,
    input  logic [REG_AW-1:0] rs1,
    input  logic              rs2_re,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rd_we,
    input  logic [REG_AW-1:0] rd,
    output logic              hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_re && (rs1 == rd);
    assign rs2_hit = rs2_re && (rs2 == rd);
    assign hazard  = rd_we && (rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID and ID/EX registers of the 5-stage core.
// Optional perf counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
//
//   state      | meaning
//   ST_RUN     | normal issue; jump > multi-cycle > load-use
//   ST_MC_WAIT | EX frozen until the divider reports done
//   ST_FLUSH   | IF/ID flushed for the remaining redirect shadow
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned REG_AW       = DEF_REG_AW,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_rs1_re_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_rs2_re_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_jump_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              ex_mc_start_i,
    input  logic              ex_mc_done_i,
    output logic              pc_hold_o,
    output logic              pc_redirect_o,
    output logic [ADDR_W-1:0] pc_redirect_addr_o,
    output logic              if_id_hold_o,
    output logic              if_id_flush_o,
    output logic              id_ex_hold_o,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic              id_ex_flush_o,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o,
    output logic [31:0]       perf_ldu_cnt_o
`else
    output logic              id_ex_flush_o
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] flush_cnt_q;
    logic [2:0] flush_cnt_d;
    logic       load_use;
    logic       take_jump;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .rs1_re (id_rs1_re_i),
        .rs1    (id_rs1_i),
        .rs2_re (id_rs2_re_i),
        .rs2    (id_rs2_i),
        .rd_we  (ex_load_i),
        .rd     (ex_rd_i),
        .hazard (load_use)
    );

    always_comb begin
        pc_hold_o          = 1'b0;
        pc_redirect_o      = 1'b0;
        pc_redirect_addr_o = '0;
        if_id_hold_o       = 1'b0;
        if_id_flush_o      = 1'b0;
        id_ex_hold_o       = 1'b0;
        id_ex_flush_o      = 1'b0;
        state_d            = state_q;
        flush_cnt_d        = flush_cnt_q;
        take_jump          = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_jump_i) begin
                    take_jump = 1'b1;
                end else if (ex_mc_start_i) begin
                    pc_hold_o    = 1'b1;
                    if_id_hold_o = 1'b1;
                    id_ex_hold_o = 1'b1;
                    if (!ex_mc_done_i) begin
                        state_d = ST_MC_WAIT;
                    end
                end else if (load_use) begin
                    pc_hold_o     = 1'b1;
                    if_id_hold_o  = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                if (ex_mc_done_i) begin
                    state_d = ST_RUN;
                end else begin
                    pc_hold_o    = 1'b1;
                    if_id_hold_o = 1'b1;
                    id_ex_hold_o = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (ex_jump_i) begin
                    take_jump = 1'b1;
                end else begin
                    // ID holds a NOP here, so stall detection is pointless
                    if_id_flush_o = 1'b1;
                    flush_cnt_d   = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase

        if (take_jump) begin
            pc_redirect_o      = 1'b1;
            pc_redirect_addr_o = ex_jump_addr_i;
            if_id_flush_o      = 1'b1;
            id_ex_flush_o      = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        end

        if (rst) begin
            pc_hold_o          = 1'b0;
            pc_redirect_o      = 1'b0;
            pc_redirect_addr_o = '0;
            if_id_hold_o       = 1'b0;
            if_id_flush_o      = 1'b0;
            id_ex_hold_o       = 1'b0;
            id_ex_flush_o      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // hold on PC together with an ID/EX bubble only happens for a load-use stall
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
            perf_ldu_cnt_o   <= '0;
        end else begin
            if (pc_hold_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
            if (if_id_flush_o && (perf_flush_cnt_o != 32'hFFFF_FFFF)) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            end
            if (pc_hold_o && id_ex_flush_o && (perf_ldu_cnt_o != 32'hFFFF_FFFF)) begin
                perf_ldu_cnt_o <= perf_ldu_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (FLUSH_CYCLES=3): directed vector table, then random
// traffic against a cycle-level reference model. Honors PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

    localparam int FC = 3;

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_LDU  = 6'b101001;
    localparam logic [5:0] O_JMP  = 6'b010101;
    localparam logic [5:0] O_FL   = 6'b000100;
    localparam logic [5:0] O_MC   = 6'b101010;

    typedef struct {
        logic        rst;
        logic        rs1_re;
        logic [4:0]  rs1;
        logic        rs2_re;
        logic [4:0]  rs2;
        logic        load;
        logic [4:0]  rd;
        logic        jump;
        logic [31:0] addr;
        logic        mcs;
        logic        mcd;
        logic [5:0]  exp;
        logic [31:0] exp_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_rs1_re_i = 1'b0;
    logic [4:0]  id_rs1_i = '0;
    logic        id_rs2_re_i = 1'b0;
    logic [4:0]  id_rs2_i = '0;
    logic        ex_load_i = 1'b0;
    logic [4:0]  ex_rd_i = '0;
    logic        ex_jump_i = 1'b0;
    logic [31:0] ex_jump_addr_i = '0;
    logic        ex_mc_start_i = 1'b0;
    logic        ex_mc_done_i = 1'b0;
    logic        pc_hold_o;
    logic        pc_redirect_o;
    logic [31:0] pc_redirect_addr_o;
    logic        if_id_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_hold_o;
    logic        id_ex_flush_o;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_flush_cnt_o;
    logic [31:0] perf_ldu_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: "are we waiting on the divider" and "flush cycles still owed"
    bit          m_in_mc = 1'b0;
    int          m_flush_rem = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    int unsigned m_ldu = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (FC),
        .REG_AW       (5),
        .ADDR_W       (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs1_re_i        (id_rs1_re_i),
        .id_rs1_i           (id_rs1_i),
        .id_rs2_re_i        (id_rs2_re_i),
        .id_rs2_i           (id_rs2_i),
        .ex_load_i          (ex_load_i),
        .ex_rd_i            (ex_rd_i),
        .ex_jump_i          (ex_jump_i),
        .ex_jump_addr_i     (ex_jump_addr_i),
        .ex_mc_start_i      (ex_mc_start_i),
        .ex_mc_done_i       (ex_mc_done_i),
        .pc_hold_o          (pc_hold_o),
        .pc_redirect_o      (pc_redirect_o),
        .pc_redirect_addr_o (pc_redirect_addr_o),
        .if_id_hold_o       (if_id_hold_o),
        .if_id_flush_o      (if_id_flush_o),
        .id_ex_hold_o       (id_ex_hold_o),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .id_ex_flush_o      (id_ex_flush_o),
        .perf_stall_cnt_o   (perf_stall_cnt_o),
        .perf_flush_cnt_o   (perf_flush_cnt_o),
        .perf_ldu_cnt_o     (perf_ldu_cnt_o)
`else
        .id_ex_flush_o      (id_ex_flush_o)
`endif
    );

    function automatic vec_t mk(bit r, bit r1e, int r1, bit r2e, int r2, bit ld, int rd,
                                bit j, logic [31:0] a, bit ms, bit md,
                                logic [5:0] e, logic [31:0] ea);
        vec_t v;
        v.rst = r;   v.rs1_re = r1e; v.rs1 = 5'(r1); v.rs2_re = r2e; v.rs2 = 5'(r2);
        v.load = ld; v.rd = 5'(rd);  v.jump = j;     v.addr = a;
        v.mcs = ms;  v.mcd = md;     v.exp = e;      v.exp_addr = ea;
        return v;
    endfunction

    // one cycle: drive, predict, compare at negedge, advance model after posedge
    task automatic step(input vec_t v, input bit use_tbl, input string name);
        logic [5:0]  e;
        logic [31:0] ea;
        logic [5:0]  got;
        bit          ldu;
        bit          ldu_ev;
        bit          n_mc;
        int          n_fr;

        rst = v.rst;           id_rs1_re_i = v.rs1_re; id_rs1_i = v.rs1;
        id_rs2_re_i = v.rs2_re; id_rs2_i = v.rs2;      ex_load_i = v.load;
        ex_rd_i = v.rd;        ex_jump_i = v.jump;     ex_jump_addr_i = v.addr;
        ex_mc_start_i = v.mcs; ex_mc_done_i = v.mcd;

        ldu = v.load && (v.rd != 0) &&
              ((v.rs1_re && v.rs1 == v.rd) || (v.rs2_re && v.rs2 == v.rd));
        e = O_NONE; ea = '0; ldu_ev = 1'b0; n_mc = m_in_mc; n_fr = m_flush_rem;
        if (v.rst) begin
            n_mc = 1'b0; n_fr = 0;
        end else if (m_in_mc) begin
            if (v.mcd) n_mc = 1'b0;
            else e = O_MC;
        end else if (v.jump) begin
            e = O_JMP; ea = v.addr; n_fr = FC - 1;
        end else if (m_flush_rem > 0) begin
            e = O_FL; n_fr = m_flush_rem - 1;
        end else if (v.mcs) begin
            e = O_MC; n_mc = !v.mcd;
        end else if (ldu) begin
            e = O_LDU; ldu_ev = 1'b1;
        end

        @(negedge clk);
        got = {pc_hold_o, pc_redirect_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o};
        n_cmp++;
        if (got !== e || pc_redirect_addr_o !== ea) begin
            n_bad++;
            $display("FAIL %s model: got %b/%h required %b/%h", name, got, pc_redirect_addr_o, e, ea);
        end
        if (use_tbl) begin
            n_cmp++;
            if (got !== v.exp || pc_redirect_addr_o !== v.exp_addr) begin
                n_bad++;
                $display("FAIL %s table: got %b/%h required %b/%h", name, got,
                         pc_redirect_addr_o, v.exp, v.exp_addr);
            end
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        n_cmp++;
        if (perf_stall_cnt_o !== m_stall || perf_flush_cnt_o !== m_flush || perf_ldu_cnt_o !== m_ldu) begin
            n_bad++;
            $display("FAIL %s perf: got %0d/%0d/%0d required %0d/%0d/%0d", name, perf_stall_cnt_o,
                     perf_flush_cnt_o, perf_ldu_cnt_o, m_stall, m_flush, m_ldu);
        end
`endif

        @(posedge clk);
        #1;
        m_in_mc = n_mc;
        m_flush_rem = n_fr;
        if (v.rst) begin
            m_stall = 0; m_flush = 0; m_ldu = 0;
        end else begin
            m_stall += int'(e[5]);
            m_flush += int'(e[2]);
            m_ldu   += int'(ldu_ev);
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rv;

        //            rst r1e r1 r2e r2 ld rd jmp addr          ms md  expected  addr
        tbl.push_back(mk(1, 1, 5, 0, 0, 1, 5, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 1, 5, 0, 0, 1, 5, 0, 32'h0,         0, 0, O_LDU,  32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 5, 0, 0, 1, 5, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 1, 7, 0, 32'h0,         0, 0, O_LDU,  32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 0, 7, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100, 0, 0, O_JMP,  32'h0000_0100));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 3, 0, 32'h0,         0, 0, O_FL,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 0, O_FL,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 0, O_MC,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200, 0, 0, O_MC,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_MC,   32'h0));
        tbl.push_back(mk(0, 1, 4, 0, 0, 1, 4, 0, 32'h0,         1, 0, O_MC,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_MC,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 1, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 1, O_MC,   32'h0));
        tbl.push_back(mk(0, 1, 9, 0, 0, 1, 9, 0, 32'h0,         0, 0, O_LDU,  32'h0));
        tbl.push_back(mk(0, 1, 9, 0, 0, 1, 9, 1, 32'h0000_0300, 1, 0, O_JMP,  32'h0000_0300));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_FL,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0400, 0, 0, O_JMP,  32'h0000_0400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_FL,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_FL,   32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 0, O_MC,   32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 0, 0, O_JMP,  32'h0000_0500));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, O_NONE, 32'h0));
        tbl.push_back(mk(0, 1, 2, 1, 6, 1, 6, 0, 32'h0,         0, 0, O_LDU,  32'h0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b1, $sformatf("tbl[%0d]", i));
        end

        for (int i = 0; i < 2000; i++) begin
            rv.rst    = ($urandom_range(63) == 0);
            rv.rs1_re = $urandom_range(1);
            rv.rs1    = 5'($urandom_range(3));
            rv.rs2_re = $urandom_range(1);
            rv.rs2    = 5'($urandom_range(3));
            rv.load   = $urandom_range(1);
            rv.rd     = 5'($urandom_range(3));
            rv.jump   = ($urandom_range(7) == 0);
            rv.addr   = $urandom;
            rv.mcs    = ($urandom_range(7) == 0);
            rv.mcd    = ($urandom_range(3) == 0);
            rv.exp    = O_NONE;
            rv.exp_addr = '0;
            step(rv, 1'b0, $sformatf("rnd[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
